// File: rtl/emu_clk_mgr.sv
// rtl/emu_clk_mgr.sv - emulator clock manager: divide-by-2 emu_clk, run/halt/step control,
// per-channel clock-enable dividers and emulated-cycle counter, all in the emu_clk_2x domain.
module emu_clk_mgr #(
    parameter int N_CH   = 4,
    parameter int DIV_W  = 16,
    parameter int STEP_W = 32,
    parameter int CNT_W  = 64,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              emu_clk_2x,
    input  logic              emu_rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              emu_clk,
    output logic              emu_tick,
    output logic [N_CH-1:0]   ch_ce,
    output logic [CNT_W-1:0]  emu_cycles,
    output logic              running,
    output logic              step_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t            state;
    state_t            state_nxt;
    logic              phase;
    logic [STEP_W-1:0] remaining;
    logic [DIV_W-1:0]  div_q [N_CH];
    logic [DIV_W-1:0]  cnt_q [N_CH];

    logic accept;
    logic halt_acc;
    logic step_load;
    logic active;
    logic tick_now;
    logic step_fin;

    assign emu_clk   = phase;
    assign cmd_ready = ~phase;
    assign running   = (state != S_IDLE);

    // Commands are only taken in the low phase, so a HALT can never cut a pulse short.
    assign accept    = cmd_valid & ~phase;
    assign halt_acc  = accept & (cmd_op == OP_HALT);
    assign step_load = accept & (cmd_op == OP_STEP) & (cmd_arg != '0);
    assign active    = (state != S_IDLE) & ~halt_acc;
    assign tick_now  = active & ~phase;
    assign step_fin  = (state == S_STEP) & phase & (remaining == STEP_W'(1));

    always_ff @(posedge emu_clk_2x) begin
        if (emu_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (step_fin) begin
            state_nxt = S_IDLE;
        end
        if (accept) begin
            case (cmd_op)
                OP_HALT:  state_nxt = S_IDLE;
                OP_RUN:   state_nxt = S_RUN;
                OP_STEP:  if (cmd_arg != '0) state_nxt = S_STEP;
                default:  state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge emu_clk_2x) begin
        if (emu_rst) begin
            phase      <= 1'b0;
            emu_tick   <= 1'b0;
            ch_ce      <= '0;
            step_done  <= 1'b0;
            emu_cycles <= '0;
            remaining  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                div_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            phase     <= active & ~phase;
            emu_tick  <= tick_now;
            step_done <= step_fin;

            if (accept && (cmd_op == OP_CLEAR)) begin
                emu_cycles <= '0;
            end else if (tick_now) begin
                emu_cycles <= emu_cycles + 1'b1;
            end

            if (step_load) begin
                remaining <= cmd_arg;
            end else if ((state == S_STEP) && phase) begin
                remaining <= remaining - 1'b1;
            end

            // Out-of-range cfg_ch matches no channel, so such writes fall through harmlessly.
            for (int i = 0; i < N_CH; i++) begin
                ch_ce[i] <= tick_now & (cnt_q[i] == '0);
                if (cfg_wr && (cfg_ch == CH_W'(i))) begin
                    div_q[i] <= cfg_div;
                    cnt_q[i] <= '0;
                end else if (tick_now) begin
                    cnt_q[i] <= (cnt_q[i] == '0) ? div_q[i] : cnt_q[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_emu_clk_mgr.sv
// tb/tb_emu_clk_mgr.sv - self-checking bench for emu_clk_mgr against a pulse-level reference model.
module tb_emu_clk_mgr;

    localparam int N_CH   = 5;
    localparam int DIV_W  = 16;
    localparam int STEP_W = 32;
    localparam int CNT_W  = 8;
    localparam int CH_W   = 3;

    localparam logic [1:0] OP_HALT  = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    logic              clk = 1'b0;
    logic              emu_rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_arg;
    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              emu_clk;
    logic              emu_tick;
    logic [N_CH-1:0]   ch_ce;
    logic [CNT_W-1:0]  emu_cycles;
    logic              running;
    logic              step_done;

    always #5 clk = ~clk;

    emu_clk_mgr #(
        .N_CH   (N_CH),
        .DIV_W  (DIV_W),
        .STEP_W (STEP_W),
        .CNT_W  (CNT_W)
    ) dut (
        .emu_clk_2x (clk),
        .emu_rst    (emu_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .emu_clk    (emu_clk),
        .emu_tick   (emu_tick),
        .ch_ce      (ch_ce),
        .emu_cycles (emu_cycles),
        .running    (running),
        .step_done  (step_done)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: mode, current emu_clk level, pulses still owed in STEP,
    // and for each channel the number of ticks seen since it was configured.
    int               m_mode;
    bit               m_clk;
    bit               m_done;
    logic [CNT_W-1:0] m_cycles;
    longint           m_left;
    int               m_div [N_CH];
    longint           m_tk  [N_CH];
    bit               m_ce  [N_CH];

    int pulses;
    int dones;
    int ce_cnt [N_CH];

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [1:0] op,
                              input logic [STEP_W-1:0] arg, input bit wr,
                              input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] dv);
        bit acc;
        bit rise;
        bit fall;
        if (r) begin
            m_mode = M_IDLE; m_clk = 0; m_done = 0; m_cycles = '0; m_left = 0;
            for (int i = 0; i < N_CH; i++) begin
                m_div[i] = 0; m_tk[i] = 0; m_ce[i] = 0;
            end
            return;
        end
        acc    = v && !m_clk;
        m_done = 0;
        rise   = (m_mode != M_IDLE) && !m_clk && !(acc && op == OP_HALT);
        fall   = m_clk;
        for (int i = 0; i < N_CH; i++) m_ce[i] = 0;
        if (rise) begin
            m_cycles = m_cycles + 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                m_ce[i] = (m_tk[i] % (m_div[i] + 1)) == 0;
                m_tk[i]++;
            end
        end
        if (fall && m_mode == M_STEP) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = M_IDLE;
                m_done = 1;
            end
        end
        m_clk = rise;
        if (acc) begin
            case (op)
                OP_HALT:  m_mode = M_IDLE;
                OP_RUN:   m_mode = M_RUN;
                OP_STEP:  if (arg != 0) begin m_mode = M_STEP; m_left = longint'(arg); end
                default:  m_cycles = '0;
            endcase
        end
        if (wr && int'(ch) < N_CH) begin
            m_div[ch] = int'(dv);
            m_tk[ch]  = 0;
        end
    endtask

    task automatic compare_outputs();
        chk("emu_clk", emu_clk, m_clk);
        chk("emu_tick", emu_tick, m_clk);
        chk("cmd_ready", cmd_ready, !m_clk);
        chk("running", running, m_mode != M_IDLE);
        chk("step_done", step_done, m_done);
        chk("emu_cycles", emu_cycles, m_cycles);
        for (int i = 0; i < N_CH; i++) chk($sformatf("ch_ce[%0d]", i), ch_ce[i], m_ce[i]);
    endtask

    task automatic cycle(input bit r, input bit v, input logic [1:0] op,
                         input logic [STEP_W-1:0] arg, input bit wr,
                         input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] dv);
        emu_rst = r; cmd_valid = v; cmd_op = op; cmd_arg = arg;
        cfg_wr = wr; cfg_ch = ch; cfg_div = dv;
        model_step(r, v, op, arg, wr, ch, dv);
        @(posedge clk);
        #1;
        compare_outputs();
        pulses += int'(emu_clk);
        dones  += int'(step_done);
        for (int i = 0; i < N_CH; i++) ce_cnt[i] += int'(ch_ce[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, OP_HALT, '0, 0, '0, '0);
    endtask

    task automatic cmd(input logic [1:0] op, input logic [STEP_W-1:0] arg);
        cycle(0, 1, op, arg, 0, '0, '0);
    endtask

    task automatic cfg(input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] dv);
        cycle(0, 0, OP_HALT, '0, 1, ch, dv);
    endtask

    task automatic clear_tally();
        pulses = 0;
        dones  = 0;
        for (int i = 0; i < N_CH; i++) ce_cnt[i] = 0;
    endtask

    initial begin
        emu_rst = 1; cmd_valid = 0; cmd_op = OP_HALT; cmd_arg = '0;
        cfg_wr = 0; cfg_ch = '0; cfg_div = '0;
        clear_tally();

        cycle(1, 0, OP_HALT, '0, 0, '0, '0);
        cycle(1, 0, OP_HALT, '0, 0, '0, '0);
        chk("rst_cycles", emu_cycles, 0);
        chk("rst_running", running, 0);
        chk("rst_ready", cmd_ready, 1);

        // RUN: state changes next cycle, first high one cycle later
        idle(2);
        cmd(OP_RUN, '0);
        chk("run_lat_clk", emu_clk, 0);
        chk("run_lat_running", running, 1);
        idle(1);
        chk("first_high", emu_clk, 1);
        chk("ready_low_in_high", cmd_ready, 0);
        idle(4);
        chk("three_edges", emu_cycles, 3);
        chk("third_high", emu_clk, 1);

        // HALT offered while high must wait for the low phase
        cmd(OP_HALT, '0);
        chk("halt_held_off", running, 1);
        cmd(OP_HALT, '0);
        chk("halt_taken", running, 0);
        chk("halt_clk_low", emu_clk, 0);
        idle(4);
        chk("frozen_cycles", emu_cycles, 3);

        // Channel dividers {0,1,3,2,1} over 12 ticks
        cmd(OP_CLEAR, '0);
        cfg(0, 0); cfg(1, 1); cfg(2, 3); cfg(3, 2); cfg(4, 1);
        clear_tally();
        cmd(OP_RUN, '0);
        idle(24);
        chk("ce0_12ticks", ce_cnt[0], 12);
        chk("ce1_12ticks", ce_cnt[1], 6);
        chk("ce2_12ticks", ce_cnt[2], 3);
        chk("ce3_12ticks", ce_cnt[3], 4);
        chk("pulses_12", pulses, 12);
        chk("cycles_12", emu_cycles, 12);

        clear_tally();
        cfg(2, 0);
        idle(7);
        chk("ce2_reconf", ce_cnt[2], 4);
        chk("ce0_after", ce_cnt[0], 4);

        clear_tally();
        cfg(3'd5, 7);
        idle(7);
        chk("oob_ce0", ce_cnt[0], 4);
        chk("oob_ce1", ce_cnt[1], 2);
        chk("oob_ce2", ce_cnt[2], 4);

        // CLEAR wins over the coinciding increment
        cmd(OP_CLEAR, '0);
        chk("clear_wins", emu_cycles, 0);
        idle(1);
        chk("clear_hold", emu_cycles, 0);
        idle(1);
        chk("clear_then_1", emu_cycles, 1);

        cmd(OP_HALT, '0);
        cmd(OP_HALT, '0);
        cmd(OP_CLEAR, '0);
        clear_tally();
        cmd(OP_STEP, 5);
        idle(13);
        chk("step5_pulses", pulses, 5);
        chk("step5_done", dones, 1);
        chk("step5_cycles", emu_cycles, 5);
        chk("step5_idle", running, 0);

        clear_tally();
        cmd(OP_STEP, 0);
        idle(5);
        chk("step0_pulses", pulses, 0);
        chk("step0_done", dones, 0);
        chk("step0_idle", running, 0);

        // Reset landing on a high phase during STEP
        cmd(OP_STEP, 10);
        idle(3);
        chk("pre_rst_high", emu_clk, 1);
        cycle(1, 0, OP_HALT, '0, 0, '0, '0);
        chk("rst_clk", emu_clk, 0);
        chk("rst_tick", emu_tick, 0);
        chk("rst_ce", ch_ce, 0);
        chk("rst_cycles2", emu_cycles, 0);
        chk("rst_running2", running, 0);
        cmd(OP_RUN, '0);
        chk("rerun_cycles0", emu_cycles, 0);
        idle(1);
        chk("rerun_cycles1", emu_cycles, 1);

        // Randomised traffic; model comparisons run on every cycle
        for (int n = 0; n < 3000; n++) begin
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)),
                  STEP_W'($urandom_range(0, 6)),
                  $urandom_range(0, 9) == 0,
                  CH_W'($urandom_range(0, 7)),
                  DIV_W'($urandom_range(0, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/emu_clk_mgr.md
Name: emu_clk_mgr

Overview:
- Parametrised emulator clock manager in the `emu_clk_2x` domain.
- Derives `emu_clk` as a registered divide-by-2 of `emu_clk_2x`.
- Adds run/halt/single-step control through a command handshake.
- Provides N programmable per-channel clock-enable dividers and a free-running emulated-cycle counter.
- Sits between the clock generator and the MSDSL model / debug control logic.

Parameters:
- N_CH, 4, number of clock-enable channels (1..16)
- DIV_W, 16, width of each channel divide value
- STEP_W, 32, width of the step-count argument
- CNT_W, 64, width of the emulated-cycle counter

Ports:
- emu_clk_2x  in  1  sole clock
- emu_rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 HALT, 01 RUN, 10 STEP, 11 CLEAR
- cmd_arg  in  STEP_W  step count for STEP
- cfg_wr  in  1  write channel divide value
- cfg_ch  in  max(1,$clog2(N_CH))  channel index
- cfg_div  in  DIV_W  divide value D; enable period is D+1 ticks
- emu_clk  out  1  emulator clock (registered)
- emu_tick  out  1  high in every emu_clk_2x cycle where emu_clk is high
- ch_ce  out  N_CH  per-channel enable pulses, aligned with emu_tick
- emu_cycles  out  CNT_W  count of emu_clk rising edges
- running  out  1  state != IDLE
- step_done  out  1  one-cycle pulse when a STEP completes

Behaviour:
- Reset (synchronous) forces all registers and outputs on the next edge, even mid-pulse:
  - state=IDLE; phase, emu_clk, emu_tick, ch_ce, step_done = 0
  - emu_cycles=0; all div and channel counters = 0; step remaining = 0
- States are IDLE, RUN, STEP.
- IDLE: phase holds 0 and emu_tick holds 0.
- RUN/STEP, every cycle:
  - phase <= ~phase; emu_clk = phase.
  - emu_tick <= ~phase, so it coincides with emu_clk high.
  - emu_cycles <= emu_cycles + ~phase; wraps modulo 2^CNT_W.
- Timing: a RUN accepted at cycle t gives state=RUN at t+1 and the first emu_clk/emu_tick high at t+2. The period is 2 cycles at 50% duty.
- cmd_ready = (phase==0). Commands are never accepted while emu_clk is high, so halts are glitch-free.
- Command effects (take effect next cycle):
  - HALT: go to IDLE; emu_clk stays 0.
  - RUN: go to RUN; no-op if already RUN.
  - STEP with cmd_arg=N>0: load remaining=N, go to STEP.
  - STEP with N=0: no state change; step_done is not pulsed.
  - CLEAR: emu_cycles <= 0; state unchanged. If an increment coincides with CLEAR, CLEAR wins.
- STEP state:
  - remaining decrements on each high phase.
  - In the high phase where remaining==1: next cycle is state=IDLE, phase=0, step_done=1 for one cycle.
  - Exactly N emu_clk high pulses are produced.
  - A command accepted in STEP replaces it: HALT aborts, RUN converts, STEP reloads, CLEAR keeps stepping.
- Channel i:
  - ch_ce[i] <= ~phase & (state!=IDLE) & (cnt[i]==0).
  - On each tick cycle, cnt[i] <= (cnt[i]==0) ? div[i] : cnt[i]-1.
  - Result: D=0 gives a pulse on every tick; D=k gives a pulse every k+1 ticks, the first on the first tick after config.
- cfg_wr:
  - div[cfg_ch] <= cfg_div and cnt[cfg_ch] <= 0.
  - The write overrides the tick reload in the same cycle; that cycle's ch_ce uses the pre-write counter.
  - cfg_ch >= N_CH is ignored.
  - Writes are legal in any state.
- Halting freezes channel counters, which resume on the next RUN/STEP.

Test Plan:
- Reset, then RUN at cycle 5 -> emu_clk high at cycles 7,9,11…; emu_tick aligned; emu_cycles=3 after cycle 11; cmd_ready low on cycles 7,9,11.
- STEP arg=5 from IDLE -> exactly 5 emu_clk pulses, step_done one cycle after the 5th high, emu_cycles=5, running=0; STEP arg=0 -> no pulses, no step_done.
- Channels div={0,1,3,2} in RUN for 12 ticks -> ch_ce counts {12,6,3,4}; reconfig ch2 to 0 mid-run -> pulses on every subsequent tick.
- HALT asserted while emu_clk high -> not accepted until next low phase; no truncated pulse; emu_clk stays 0 and counters freeze.
- CLEAR issued while running -> emu_cycles=0 on the next cycle, then increments from 1; cfg_ch=N_CH write leaves all channels unchanged.
- emu_rst asserted with emu_clk high during STEP -> all outputs 0 the next cycle; a subsequent RUN starts cleanly with emu_cycles=0.
